// File: rtl/dest_wb_pipe.sv
// -----------------------------------------------------------------------------
// dest_wb_pipe
//
// Carries each issued instruction's destination controls through the EX, MEM
// and WB stage registers. It drives the register-file write port from WB and
// the data-memory store strobe from MEM. It also raises a RAW-hazard stall
// when a decoded source register matches a destination that is still in
// flight.
//
// Parameters
//   WB_BYPASS  1: the regfile writes through, so a WB-stage match never stalls
//              0: a match against WB also stalls
//   CNT_W      width of the saturating stall-cycle counter
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   id_valid          decode holds a real instruction
//   id_w1_reg         destination register from decode
//   id_reg_en         instruction writes the register file
//   id_mem_en         instruction writes data memory (store)
//   id_src_a/_used    source register A and whether it is read
//   id_src_b/_used    source register B and whether it is read
//   flush             kill the instruction entering EX this cycle
//   mem_ready         data memory done; low freezes EX/MEM/WB
//   stall             hold PC and decode this cycle (combinational)
//   mem_wr_en         store strobe for the instruction in MEM
//   rf_wr_en          regfile write enable for the instruction in WB
//   rf_wr_reg         regfile write address
//   stall_cnt         saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module dest_wb_pipe #(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_w1_reg,
    input  logic             id_reg_en,
    input  logic             id_mem_en,
    input  logic [2:0]       id_src_a,
    input  logic             id_src_a_used,
    input  logic [2:0]       id_src_b,
    input  logic             id_src_b_used,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             stall,
    output logic             mem_wr_en,
    output logic             rf_wr_en,
    output logic [2:0]       rf_wr_reg,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic       reg_en;
        logic       mem_en;
        logic [2:0] w1_reg;
    } stage_t;

    // The store strobe is consumed in MEM, so WB only needs the register
    // write half of the destination controls.
    typedef struct packed {
        logic       v;
        logic       reg_en;
        logic [2:0] w1_reg;
    } wb_stage_t;

    localparam bit WB_CHK = (WB_BYPASS == 1'b0);

    stage_t           ex_q, ex_d;
    stage_t           mem_q, mem_d;
    wb_stage_t        wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             pend_a;
    logic             pend_b;
    logic             haz;
    logic             stall_c;

    // A destination is pending against r when the stage holds a live
    // register-writing instruction targeting r. R0 is hardwired, never a hazard.
    function automatic logic pend(input logic v, input logic reg_en,
                                  input logic [2:0] w1_reg, input logic [2:0] r);
        return v & reg_en & (w1_reg == r) & (r != 3'd0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        pend_a = pend(ex_q.v, ex_q.reg_en, ex_q.w1_reg, id_src_a)
               | pend(mem_q.v, mem_q.reg_en, mem_q.w1_reg, id_src_a)
               | (WB_CHK & pend(wb_q.v, wb_q.reg_en, wb_q.w1_reg, id_src_a));
        pend_b = pend(ex_q.v, ex_q.reg_en, ex_q.w1_reg, id_src_b)
               | pend(mem_q.v, mem_q.reg_en, mem_q.w1_reg, id_src_b)
               | (WB_CHK & pend(wb_q.v, wb_q.reg_en, wb_q.w1_reg, id_src_b));
        haz     = id_valid & ((id_src_a_used & pend_a) | (id_src_b_used & pend_b));
        stall_c = haz | ~mem_ready;

        // Defaults hold every stage; this is the freeze behaviour, during
        // which flush is deliberately ignored.
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;

        if (mem_ready) begin
            wb_d.v      = mem_q.v;
            wb_d.reg_en = mem_q.reg_en;
            wb_d.w1_reg = mem_q.w1_reg;
            mem_d       = ex_q;
            // flush outranks a hazard-free issue; a hazard also inserts a bubble.
            if (id_valid & ~haz & ~flush) begin
                ex_d.v      = 1'b1;
                ex_d.reg_en = id_reg_en;
                ex_d.mem_en = id_mem_en;
                ex_d.w1_reg = id_w1_reg;
            end else begin
                ex_d = '0;
            end
        end

        stall_cnt_d = stall_c ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Strobes are gated by mem_ready so a frozen store or write fires exactly
    // once, in the cycle the pipeline is released.
    assign stall     = stall_c;
    assign mem_wr_en = mem_q.v & mem_q.mem_en & mem_ready;
    assign rf_wr_en  = wb_q.v & wb_q.reg_en & mem_ready;
    assign rf_wr_reg = wb_q.w1_reg;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dest_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_dest_wb_pipe
//
// Directed bench for dest_wb_pipe. Two instances share one stimulus stream:
// u_dut uses the default parameters, and u_dut2 uses WB_BYPASS=0 and CNT_W=4.
// Expected register-file writes and store strobes for u_dut are pushed to
// scoreboard queues, tagged with the cycle in which they must appear. A
// negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_dest_wb_pipe;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_w1_reg;
    logic        id_reg_en;
    logic        id_mem_en;
    logic [2:0]  id_src_a;
    logic        id_src_a_used;
    logic [2:0]  id_src_b;
    logic        id_src_b_used;
    logic        flush;
    logic        mem_ready;

    logic        stall, mem_wr_en, rf_wr_en;
    logic [2:0]  rf_wr_reg;
    logic [15:0] stall_cnt;

    logic        stall2, mem_wr_en2, rf_wr_en2;
    logic [2:0]  rf_wr_reg2;
    logic [3:0]  stall_cnt2;

    dest_wb_pipe #(.WB_BYPASS(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_w1_reg(id_w1_reg),
        .id_reg_en(id_reg_en), .id_mem_en(id_mem_en), .id_src_a(id_src_a),
        .id_src_a_used(id_src_a_used), .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
        .flush(flush), .mem_ready(mem_ready), .stall(stall), .mem_wr_en(mem_wr_en),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .stall_cnt(stall_cnt)
    );

    dest_wb_pipe #(.WB_BYPASS(1'b0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_w1_reg(id_w1_reg),
        .id_reg_en(id_reg_en), .id_mem_en(id_mem_en), .id_src_a(id_src_a),
        .id_src_a_used(id_src_a_used), .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
        .flush(flush), .mem_ready(mem_ready), .stall(stall2), .mem_wr_en(mem_wr_en2),
        .rf_wr_en(rf_wr_en2), .rf_wr_reg(rf_wr_reg2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        int         cyc;
        logic [2:0] r;
    } wr_t;

    wr_t  rf_q[$];
    int   mw_q[$];
    int   cyc;
    int   checks;
    int   failures;
    bit   mon_en;
    logic exp_rf;
    logic exp_mw;
    int   k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every cycle the write strobe must match exactly what
    // was scheduled for this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rf = (rf_q.size() > 0) && (rf_q[0].cyc == cyc);
            check("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, exp_rf});
            if (exp_rf) begin
                check("rf_wr_reg", {29'd0, rf_wr_reg}, {29'd0, rf_q[0].r});
                void'(rf_q.pop_front());
            end
            exp_mw = (mw_q.size() > 0) && (mw_q[0] == cyc);
            check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_mw});
            if (exp_mw) void'(mw_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid      = 1'b0;
        id_w1_reg     = 3'd0;
        id_reg_en     = 1'b0;
        id_mem_en     = 1'b0;
        id_src_a      = 3'd0;
        id_src_a_used = 1'b0;
        id_src_b      = 3'd0;
        id_src_b_used = 1'b0;
        flush         = 1'b0;
        mem_ready     = 1'b1;
    endtask

    task automatic issue(input logic [2:0] w, input logic re, input logic me,
                         input logic [2:0] sa, input logic sau,
                         input logic [2:0] sb, input logic sbu);
        id_valid      = 1'b1;
        id_w1_reg     = w;
        id_reg_en     = re;
        id_mem_en     = me;
        id_src_a      = sa;
        id_src_a_used = sau;
        id_src_b      = sb;
        id_src_b_used = sbu;
        flush         = 1'b0;
    endtask

    task automatic push_rf(input int c, input logic [2:0] r);
        wr_t e;
        e.cyc = c;
        e.r   = r;
        rf_q.push_back(e);
    endtask

    task automatic do_reset();
        step();
        rf_q.delete();
        mw_q.delete();
        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        idle_in();
        rst = 1'b1;
        step();
        step();
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("rst_rf_wr_reg", {29'd0, rf_wr_reg}, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1. idle for five cycles after reset
        for (int i = 0; i < 5; i++) step();
        #2;
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_rf_wr_reg", {29'd0, rf_wr_reg}, 32'd0);
        check("idle_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("idle_stall_cnt2", {28'd0, stall_cnt2}, 32'd0);

        // 2. write r3, then an independent instruction writing r4
        step();
        k = cyc;
        issue(3'd3, 1'b1, 1'b0, 3'd1, 1'b1, 3'd2, 1'b1);
        push_rf(k + 3, 3'd3);
        #2;
        check("t2_stall_i0", {31'd0, stall}, 32'd0);
        step();
        issue(3'd4, 1'b1, 1'b0, 3'd1, 1'b1, 3'd5, 1'b0);
        push_rf(k + 4, 3'd4);
        #2;
        check("t2_stall_i1", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            idle_in();
            #2;
            check("t2_stall_drain", {31'd0, stall}, 32'd0);
        end

        // 3. write r2, next instruction reads r2 as src_a
        do_reset();
        step();
        k = cyc;
        issue(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        push_rf(k + 3, 3'd2);
        step();
        issue(3'd5, 1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0);
        #2;
        check("t3_stall_c1", {31'd0, stall}, 32'd1);
        check("t3_stall2_c1", {31'd0, stall2}, 32'd1);
        step();
        #2;
        check("t3_stall_c2", {31'd0, stall}, 32'd1);
        check("t3_stall2_c2", {31'd0, stall2}, 32'd1);
        step();
        push_rf(k + 6, 3'd5);
        #2;
        check("t3_stall_c3", {31'd0, stall}, 32'd0);
        check("t3_stall2_c3", {31'd0, stall2}, 32'd1);
        step();
        idle_in();
        #2;
        check("t3_stall_cnt", {16'd0, stall_cnt}, 32'd2);
        check("t3_stall_cnt2", {28'd0, stall_cnt2}, 32'd3);
        for (int i = 0; i < 4; i++) step();

        // 4. store frozen in MEM for three cycles with a write frozen in WB
        do_reset();
        step();
        k = cyc;
        issue(3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        push_rf(k + 6, 3'd4);
        step();
        issue(3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0);
        mw_q.push_back(k + 6);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            mem_ready = 1'b0;
            #2;
            check("t4_freeze_stall", {31'd0, stall}, 32'd1);
            check("t4_freeze_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
            check("t4_freeze_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        end
        step();
        mem_ready = 1'b1;
        #2;
        check("t4_release_stall", {31'd0, stall}, 32'd0);
        check("t4_release_mem_wr_en", {31'd0, mem_wr_en}, 32'd1);
        step();
        #2;
        check("t4_after_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        for (int i = 0; i < 3; i++) step();

        // 5. r0 is never a hazard; flush turns a valid issue into a bubble
        do_reset();
        step();
        k = cyc;
        issue(3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        push_rf(k + 3, 3'd0);
        step();
        issue(3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1);
        #2;
        check("t5_r0_stall", {31'd0, stall}, 32'd0);
        check("t5_r0_stall2", {31'd0, stall2}, 32'd0);
        step();
        issue(3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b1;
        #2;
        check("t5_flush_stall", {31'd0, stall}, 32'd0);
        step();
        issue(3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        push_rf(k + 6, 3'd1);
        step();
        issue(3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
        flush = 1'b1;
        #2;
        check("t5_haz_flush_stall", {31'd0, stall}, 32'd1);
        step();
        idle_in();
        #2;
        check("t5_after_flush_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 5; i++) step();

        // 6. long frozen hazard saturates the narrow counter; rst drops a write
        do_reset();
        step();
        issue(3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        step();
        issue(3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0);
        mem_ready = 1'b0;
        #2;
        check("t6_stall_first", {31'd0, stall}, 32'd1);
        for (int i = 1; i < 20; i++) step();
        #2;
        check("t6_stall_last", {31'd0, stall}, 32'd1);
        check("t6_stall2_last", {31'd0, stall2}, 32'd1);
        step();
        idle_in();
        #2;
        check("t6_stall_cnt", {16'd0, stall_cnt}, 32'd20);
        check("t6_stall_cnt2_sat", {28'd0, stall_cnt2}, 32'd15);
        step();
        step();
        check("t6_wb_pending", {31'd0, rf_wr_en}, 32'd1);
        check("t6_wb_reg", {29'd0, rf_wr_reg}, 32'd1);
        rf_q.delete();
        mw_q.delete();
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("t6_rst_rf_wr_reg", {29'd0, rf_wr_reg}, 32'd0);
        check("t6_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
